div_operand_prep: RTL and testbench



---
 rtl/div_operand_prep.sv | 83 ++++++++
 tb/tb_div_operand_prep.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_prep.sv
// div_operand_prep: converts two's-complement operand pairs to sign-magnitude, flags dz/ovf, tags them, buffers in a 2-entry FIFO
module div_operand_prep #(
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_dividend,
  input  logic [15:0]     in_divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16:0]     out_dividend,
  output logic [16:0]     out_divisor,
  output logic            out_qsign,
  output logic            out_dz,
  output logic            out_ovf,
  output logic [TAGW-1:0] out_tag,
  output logic [7:0]      err_cnt
);
  localparam int EW = 37 + TAGW;
  logic            r_s1_valid, r_s2_valid;
  logic [16:0]     r_s1_dd, r_s1_dv, r_s2_dd, r_s2_dv;
  logic [TAGW-1:0] r_s1_tag, r_s2_tag, r_tag_cnt;
  logic [EW-1:0]   r_f0, r_f1;
  logic [1:0]      r_cnt;
  logic [7:0]      r_err;
  logic            w_pop, w_push, w_s1_adv, w_in_fire, w_dz, w_ovf, w_qsign;
  logic [15:0]     w_mag_a, w_mag_b;
  logic [EW-1:0]   w_entry;
  assign out_valid = r_cnt != 2'd0;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_s2_valid && (r_cnt != 2'd2 || w_pop);
  assign w_s1_adv  = r_s1_valid && (!r_s2_valid || w_push);
  // gated by rst_n so in_ready stays low while reset is held
  assign in_ready  = rst_n && (!r_s1_valid || w_s1_adv);
  assign w_in_fire = in_valid && in_ready;
  assign w_mag_a   = in_dividend[15] ? ~in_dividend + 16'd1 : in_dividend;
  assign w_mag_b   = in_divisor[15] ? ~in_divisor + 16'd1 : in_divisor;
  assign w_dz      = r_s2_dv[15:0] == 16'd0;
  assign w_ovf     = !w_dz && (r_s2_dd[15:0] >= r_s2_dv[15:0]);
  assign w_qsign   = r_s2_dd[16] ^ r_s2_dv[16];
  assign w_entry   = {r_s2_dd, r_s2_dv, w_qsign, w_dz, w_ovf, r_s2_tag};
  assign {out_dividend, out_divisor, out_qsign, out_dz, out_ovf, out_tag} = r_f0;
  assign err_cnt   = r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_dd    <= '0;
      r_s1_dv    <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_dd    <= '0;
      r_s2_dv    <= '0;
      r_s2_tag   <= '0;
      r_tag_cnt  <= '0;
      r_f0       <= '0;
      r_f1       <= '0;
      r_cnt      <= 2'd0;
      r_err      <= 8'd0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
        r_s1_dd    <= {in_dividend[15], w_mag_a};
        r_s1_dv    <= {in_divisor[15], w_mag_b};
        r_s1_tag   <= r_tag_cnt;
      end
      if (w_in_fire) r_tag_cnt <= r_tag_cnt + TAGW'(1);
      if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
        r_s2_dd    <= r_s1_dd;
        r_s2_dv    <= r_s1_dv;
        r_s2_tag   <= r_s1_tag;
      end else if (w_push) r_s2_valid <= 1'b0;
      if (w_push && (w_dz || w_ovf) && r_err != 8'hFF) r_err <= r_err + 8'd1;
      // head register always holds the oldest entry; a pop shifts entry 1 down
      if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_f0 <= w_entry;
      else if (w_pop && r_cnt == 2'd2) r_f0 <= r_f1;
      if (w_push && ((r_cnt == 2'd1 && !w_pop) || r_cnt == 2'd2)) r_f1 <= w_entry;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_div_operand_prep.sv
// tb_div_operand_prep: randomized scoreboard bench for div_operand_prep with an arithmetic reference model
module tb_div_operand_prep;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_dividend = '0;
  logic [15:0] in_divisor = '0;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_dividend, out_divisor;
  logic        out_qsign, out_dz, out_ovf;
  logic [3:0]  out_tag;
  logic [7:0]  err_cnt;
  logic [40:0] sb[$];
  logic [40:0] cur, held;
  logic        held_v = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  mtag = '0;
  int          merr = 0;
  int          total = 0;
  int          bad = 0;

  div_operand_prep #(.TAGW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .out_valid(out_valid),
    .out_ready(out_ready), .out_dividend(out_dividend), .out_divisor(out_divisor),
    .out_qsign(out_qsign), .out_dz(out_dz), .out_ovf(out_ovf), .out_tag(out_tag),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  assign cur = {out_dividend, out_divisor, out_qsign, out_dz, out_ovf, out_tag};

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready = (mode == 2'd2) ? 1'($urandom % 2) : mode[0];
    end
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  // reference: plain integer abs/compare on the signed operand values
  function automatic logic [40:0] model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int sa, sb_, ma, mb;
    logic dz, ovf;
    sa = $signed(a);
    sb_ = $signed(b);
    ma = sa < 0 ? -sa : sa;
    mb = sb_ < 0 ? -sb_ : sb_;
    dz = mb == 0;
    ovf = !dz && ma >= mb;
    return {sa < 0, ma[15:0], sb_ < 0, mb[15:0], (sa < 0) ^ (sb_ < 0), dz, ovf, t};
  endfunction

  task automatic accept(input logic [15:0] a, input logic [15:0] b);
    logic [40:0] e;
    e = model(a, b, mtag);
    sb.push_back(e);
    mtag = mtag + 4'd1;
    if ((e[5] || e[4]) && merr < 255) merr++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) held_v = 1'b0;
    else begin
      if (held_v && out_valid) chk("head_stable", cur, held);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_output actual=%h expected=none", cur);
        end else chk("scoreboard", cur, sb.pop_front());
      end
      held_v = out_valid && !out_ready;
      held = cur;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) accept(a, b);
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=no_accept expected=accept");
    end
  endtask

  task automatic dir(input logic [15:0] a, input logic [15:0] b, input logic [40:0] exp, input logic [7:0] exp_err);
    in_valid = 1'b1;
    in_dividend = a;
    in_divisor = b;
    @(negedge clk);
    chk("dir_in_ready", in_ready, 1);
    if (in_ready) accept(a, b);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_k", out_valid, 0);
    @(negedge clk);
    chk("lat_k1", out_valid, 0);
    @(negedge clk);
    chk("lat_k2", out_valid, 1);
    chk("dir_fields", cur, exp);
    chk("dir_err", err_cnt, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", {31'd0, sb.size() == 0 && !out_valid}, 1);
    chk("drain_err", err_cnt, merr[7:0]);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_op();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? 16'h0000 : k == 1 ? 16'h8000 : 16'($urandom);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_data", {out_dividend, out_divisor}, 0);
    chk("rst_flags", {out_qsign, out_dz, out_ovf, out_tag}, 0);
    chk("rst_err", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dir(16'h0A0A, 16'hE5E6, {17'h00A0A, 17'h11A1A, 1'b1, 1'b0, 1'b0, 4'd0}, 8'd0);
    dir(16'h8000, 16'h8000, {17'h18000, 17'h18000, 1'b0, 1'b0, 1'b1, 4'd1}, 8'd1);
    dir(16'h1234, 16'h0000, {17'h01234, 17'h00000, 1'b0, 1'b1, 1'b0, 4'd2}, 8'd2);
    drain();
    @(negedge clk);
    mode = 2'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    mode = 2'd1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) send(16'($urandom), 16'($urandom));
    drain();
    @(negedge clk);
    mode = 2'd2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 40; i++) send(rnd_op(), rnd_op());
    @(negedge clk);
    mode = 2'd1;
    drain();
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(16'h0100, 16'h7FFF));
      if ($urandom % 2 == 1) a = -a;
      b = 16'($urandom_range(1, 255));
      send(a, b);
    end
    drain();
    chk("err_sat", err_cnt, 8'd255);
    @(negedge clk);
    mode = 2'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_outs", cur, 0);
    chk("midrst_err", err_cnt, 0);
    sb.delete();
    mtag = '0;
    merr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    dir(16'h0100, 16'h0200, {17'h00100, 17'h00200, 1'b0, 1'b0, 1'b0, 4'd0}, 8'd0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
